// File: rtl/arb4_rr_ctrl.sv
// Four-client round-robin arbiter with a programmable maximum hold time.
// Grants are registered and one-hot; every hand-over passes through at least
// one idle cycle so the shared resource never sees two owners back to back.
module arb4_rr_ctrl #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  // Hold counter value on which the limit fires; unused when the limit is off.
  localparam bit         HOLD_EN   = (MAX_HOLD != 0);
  localparam logic [7:0] HOLD_LAST = (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);

  state_t     r_state;
  logic [3:0] r_gnt;
  logic [1:0] r_gnt_id;
  logic       r_gnt_valid;
  logic       r_timeout;
  logic [1:0] r_last;
  logic [7:0] r_cnt;

  logic [2:0] w_pick;
  logic       w_rel_req;
  logic       w_rel_en;
  logic       w_rel_hold;
  logic       w_release;

  // Search last+1, last+2, last+3, last; returns {found, id}. Iterating from
  // the farthest offset down lets the nearest requester overwrite the result.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign w_pick     = rr_pick(req, r_last);
  assign w_rel_req  = ~req[r_gnt_id];
  assign w_rel_en   = ~en;
  assign w_rel_hold = HOLD_EN && (r_cnt == HOLD_LAST);
  assign w_release  = w_rel_req | w_rel_en | w_rel_hold;

  // Arbitration FSM; every output is a register so nothing is combinational
  // from inputs to outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_gnt       <= 4'b0000;
      r_gnt_id    <= 2'b00;
      r_gnt_valid <= 1'b0;
      r_timeout   <= 1'b0;
      r_last      <= 2'b11;
      r_cnt       <= 8'd0;
    end else begin
      case (r_state)
        S_BUSY: begin
          if (w_release) begin
            r_state     <= S_IDLE;
            r_gnt       <= 4'b0000;
            r_gnt_id    <= 2'b00;
            r_gnt_valid <= 1'b0;
            // A dropped request or disable wins over the hold limit.
            r_timeout   <= w_rel_hold & ~w_rel_req & ~w_rel_en;
          end else begin
            r_timeout <= 1'b0;
            if (r_cnt != 8'hFF) r_cnt <= r_cnt + 8'd1;
          end
        end
        default: begin
          r_timeout <= 1'b0;
          if (en && w_pick[2]) begin
            r_state     <= S_BUSY;
            r_gnt       <= 4'b0001 << w_pick[1:0];
            r_gnt_id    <= w_pick[1:0];
            r_gnt_valid <= 1'b1;
            r_last      <= w_pick[1:0];
            r_cnt       <= 8'd0;
          end
        end
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign gnt_id    = r_gnt_id;
  assign gnt_valid = r_gnt_valid;
  assign timeout   = r_timeout;

endmodule
